conv1_mem_write: RTL
====================

Name: conv1_mem_write

Overview:
Write-side address generator for the Convolution 1 layer output memory. It accepts the conv1 result stream in raster order (row-major, one pixel per accepted beat) and produces registered write-enable, address and data for the 24x24 output map. Its layout matches the read side's 2x2 pooling scan: address = row*IMG_W + col, final address 575. It raises done once the full map is stored, which releases the pooling read stage.

Parameters:
IMG_W, 24, output map width in pixels
IMG_H, 24, output map height in pixels
ADDR_W, 10, memory address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W
DATA_W, 16, conv1 result word width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  layer enable; low pauses acceptance, no state lost
start  input  1  one-cycle pulse; arms a new frame from IDLE or DONE
in_valid  input  1  conv1 result present on in_data
in_data  input  DATA_W  conv1 result word
in_ready  output  1  block accepts a beat this cycle
wr_en  output  1  memory write strobe, registered
wr_addr  output  ADDR_W  memory write address, registered
wr_data  output  DATA_W  memory write data, registered
done  output  1  full map written; level, held until start or reset
overflow  output  1  sticky; in_valid seen while in DONE

Behaviour:
- Reset (reset low, async): state=IDLE, col=0, row=0, wr_en=0, wr_addr=0, wr_data=0, done=0, overflow=0. Reset mid-frame discards the partial frame. The next frame needs start again.
- States: IDLE, WRITE, DONE.
- IDLE: in_ready=0. start=1 moves to WRITE with col=row=0.
- WRITE: in_ready = enable. A beat is accepted when in_valid && in_ready.
- On an accepted beat, next cycle: wr_en=1, wr_addr=row*IMG_W+col, wr_data=in_data. Latency is 1 cycle. wr_en=0 in any cycle after a non-accepted beat.
- Address is kept as a running counter (+1 per beat), with col/row tracked separately. No multiplier.
- col wraps IMG_W-1 -> 0 with row+1.
- Beat at col=IMG_W-1, row=IMG_H-1 (address 575): the write is issued next cycle and the state moves to DONE in that same cycle, so done=1 coincides with the final wr_en.
- DONE: in_ready=0, done=1. in_valid=1 sets overflow (sticky until reset or start) and data is dropped. start clears done and overflow, zeroes the counters and enters WRITE.
- start during WRITE is ignored.
- enable low in WRITE: in_ready=0, counters frozen, wr_en=0 the next cycle. Resumes at the same address.
- in_ready is combinational from state and enable only, never from in_valid.
- wr_addr holds its last value when wr_en=0.

Test Plan:
- Reset then start, stream 576 back-to-back beats in_data=k -> wr_en high 576 cycles, wr_addr 0..575 with wr_data=k at address k, done=1 on the cycle of wr_addr=575, in_ready=0 after.
- Row wrap: beats 23, 24, 25 -> wr_addr 23, 24, 25; internal row=1, col=0 at beat 24.
- enable low for 5 cycles after beat 100 -> no wr_en in the gap, next write is addr 101 with the correct data, total count still 576.
- in_valid toggling every other cycle -> wr_en mirrors accepts one cycle later, addresses contiguous, done after the 576th accept.
- In DONE, drive in_valid=1 -> overflow=1, no wr_en. Then start -> overflow=0, done=0, next beat writes addr 0.
- Assert reset low asynchronously at beat 300 -> outputs zero immediately, state IDLE, in_ready=0. start then a new stream -> first write to addr 0.

Source files
------------

// File: rtl/conv1_mem_write.sv
// Conv1 output-map write-side address generator: turns the raster-order result
// stream into registered memory writes and flags completion of the 24x24 map.
module conv1_mem_write #(
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              done,
    output logic              overflow
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr_cnt;
    logic              accept;
    logic              last_beat;

    // Ready depends only on state and enable so upstream can never loop through in_valid.
    assign in_ready  = (state == WRITE) && enable;
    assign accept    = in_valid && in_ready;
    assign last_beat = (col == COL_LAST) && (row == ROW_LAST);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            addr_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WRITE;
                        col      <= '0;
                        row      <= '0;
                        addr_cnt <= '0;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_cnt;
                        wr_data <= in_data;
                        // Final pixel: done rises together with its write strobe.
                        if (last_beat) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            addr_cnt <= addr_cnt + ADDR_ONE;
                            if (col == COL_LAST) begin
                                col <= '0;
                                row <= row + ROW_ONE;
                            end else begin
                                col <= col + COL_ONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state    <= WRITE;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                        col      <= '0;
                        row      <= '0;
                        addr_cnt <= '0;
                    end else if (in_valid) begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
